// File: rtl/monpro_pkg.sv
// Shared types and constants for the word-serial Montgomery product engine.
package monpro_pkg;

  localparam int WORD_W_DEF    = 128;
  localparam int NUM_WORDS_DEF = 32;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_X = 4'd1,
    S_LOAD_Y = 4'd2,
    S_LOAD_N = 4'd3,
    S_MUL    = 4'd4,
    S_RED    = 4'd5,
    S_SUB    = 4'd6,
    S_OUT    = 4'd7
  } state_t;

  function automatic int cnt_width(input int num_words);
    return $clog2(num_words + 2);
  endfunction

  // Cycles from the last accepted operand word to the first result word.
  function automatic int latency(input int num_words);
    return num_words * (2 * num_words + 2) + num_words + 1;
  endfunction

  localparam int LATENCY_DEF = latency(NUM_WORDS_DEF);

endpackage

// File: rtl/monpro_stream_mac.sv
// Combinational multiply-accumulate: a*b + c + d, never overflows 2*WORD_W bits.
module mac_word #(
  parameter int WORD_W = 128
) (
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  input  logic [WORD_W-1:0]   c,
  input  logic [WORD_W-1:0]   d,
  output logic [2*WORD_W-1:0] p
);
  localparam int PW = 2 * WORD_W;

  assign p = PW'(a) * PW'(b) + PW'(c) + PW'(d);

endmodule

// File: rtl/monpro_stream.sv
// Word-serial CIOS Montgomery product x*y*R^-1 mod n with streamed operands and result.
// Handshake: a word moves when in_valid & in_ready; out_valid has no backpressure.
module monpro_stream
  import monpro_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sq_mode,
  input  logic              keep_n,
  input  logic [WORD_W-1:0] n_prime,
  input  logic [WORD_W-1:0] inp,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] outp,
  output logic              out_valid,
  output logic              done,
  output logic [3:0]        state
);
  localparam int CW = cnt_width(NUM_WORDS);
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  state_t state_q, state_next;
  logic [CW-1:0] cnt, outer, cnt_m1, cnt_m2;
  logic [IW-1:0] j_idx, jm1_idx, i_idx;
  logic sq_q, keep_q, n_loaded, borrow_q, t_top;
  logic [WORD_W-1:0] carry, m_q;
  logic [WORD_W-1:0] x_buf [NUM_WORDS];
  logic [WORD_W-1:0] y_buf [NUM_WORDS];
  logic [WORD_W-1:0] n_buf [NUM_WORDS];
  logic [WORD_W-1:0] t_buf [NUM_WORDS+1];

  logic in_load, accept, last_word, last_step, need_n, enter_mul, sel_d, borrow_in;
  logic [WORD_W-1:0] mac_a, mac_b, mac_c, mac_d, mac_lo, mac_hi;
  logic [2*WORD_W-1:0] mac_p;
  logic [WORD_W:0] fold_sum, diff;

  assign cnt_m1    = cnt - CW'(1);
  assign cnt_m2    = cnt - CW'(2);
  assign j_idx     = cnt[IW-1:0];
  assign jm1_idx   = cnt_m1[IW-1:0];
  assign i_idx     = outer[IW-1:0];
  assign in_load   = (state_q == S_LOAD_X) || (state_q == S_LOAD_Y) || (state_q == S_LOAD_N);
  assign accept    = in_valid & in_load;
  assign last_word = (cnt == CW'(NUM_WORDS - 1));
  assign last_step = (cnt == CW'(NUM_WORDS));
  assign need_n    = ~keep_q | ~n_loaded;
  assign enter_mul = in_load && (state_next == S_MUL);

  // After SUB, y_buf holds t - n; pick it unless the subtraction underflowed.
  assign sel_d     = (t_buf[NUM_WORDS] != '0) | ~borrow_q;
  assign in_ready  = in_load;
  assign out_valid = (state_q == S_OUT);
  assign done      = out_valid & last_word;
  assign outp      = out_valid ? (sel_d ? y_buf[j_idx] : t_buf[cnt]) : '0;
  assign state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE:   if (start) state_next = S_LOAD_X;
      S_LOAD_X: if (accept && last_word)
                  state_next = !sq_q ? S_LOAD_Y : (need_n ? S_LOAD_N : S_MUL);
      S_LOAD_Y: if (accept && last_word) state_next = need_n ? S_LOAD_N : S_MUL;
      S_LOAD_N: if (accept && last_word) state_next = S_MUL;
      S_MUL:    if (last_step) state_next = S_RED;
      S_RED:    if (last_step) state_next = (outer == CW'(NUM_WORDS - 1)) ? S_SUB : S_MUL;
      S_SUB:    if (last_word) state_next = S_OUT;
      S_OUT:    if (last_word) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // MUL: t_j += x_j*y_i + carry.  RED step 0: m = t_0*n'; steps 1..N: t_{j-1} = t_j + m*n_j + carry.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    mac_d = '0;
    case (state_q)
      S_MUL: begin
        mac_d = carry;
        if (!last_step) begin
          mac_a = x_buf[j_idx];
          mac_b = sq_q ? x_buf[i_idx] : y_buf[i_idx];
          mac_c = t_buf[cnt];
        end else begin
          mac_c = t_buf[NUM_WORDS];
        end
      end
      S_RED: begin
        if (cnt == '0) begin
          mac_a = t_buf[0];
          mac_b = n_prime;
        end else begin
          mac_a = m_q;
          mac_b = n_buf[jm1_idx];
          mac_c = t_buf[cnt_m1];
          mac_d = carry;
        end
      end
      default: ;
    endcase
  end

  mac_word #(.WORD_W(WORD_W)) u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .d (mac_d),
    .p (mac_p)
  );

  assign mac_lo    = mac_p[WORD_W-1:0];
  assign mac_hi    = mac_p[2*WORD_W-1:WORD_W];
  assign fold_sum  = {1'b0, t_buf[NUM_WORDS]} + {1'b0, mac_hi};
  assign borrow_in = (cnt != '0) & borrow_q;
  assign diff      = {1'b0, t_buf[cnt]} - {1'b0, n_buf[j_idx]} - (WORD_W+1)'(borrow_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      outer    <= '0;
      sq_q     <= 1'b0;
      keep_q   <= 1'b0;
      n_loaded <= 1'b0;
      carry    <= '0;
      m_q      <= '0;
      borrow_q <= 1'b0;
    end else begin
      if (state_next != state_q)
        cnt <= '0;
      else if (accept || (!in_load && state_q != S_IDLE))
        cnt <= cnt + CW'(1);
      if (enter_mul)
        outer <= '0;
      else if (state_q == S_RED && last_step)
        outer <= outer + CW'(1);
      if (state_q == S_IDLE && start) begin
        sq_q   <= sq_mode;
        keep_q <= keep_n;
      end
      if (state_q == S_LOAD_N && accept && last_word)
        n_loaded <= 1'b1;
      if (enter_mul)
        carry <= '0;
      case (state_q)
        S_MUL: carry <= last_step ? '0 : mac_hi;
        S_RED: begin
          if (cnt == '0) m_q   <= mac_lo;
          else           carry <= last_step ? '0 : mac_hi;
        end
        S_SUB: borrow_q <= diff[WORD_W];
        default: ;
      endcase
    end
  end

  // Operand and accumulator storage is not reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state_q)
        S_LOAD_X: x_buf[j_idx] <= inp;
        S_LOAD_Y: y_buf[j_idx] <= inp;
        S_LOAD_N: n_buf[j_idx] <= inp;
        default: ;
      endcase
    end
    if (enter_mul) begin
      for (int k = 0; k <= NUM_WORDS; k++) t_buf[k] <= '0;
      t_top <= 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          if (!last_step) begin
            t_buf[cnt] <= mac_lo;
          end else begin
            t_buf[NUM_WORDS] <= mac_lo;
            t_top            <= mac_hi[0];
          end
        end
        S_RED: begin
          if (cnt >= CW'(2)) t_buf[cnt_m2] <= mac_lo;
          // Last step also folds the carry into the top words of the shifted accumulator.
          if (last_step) begin
            t_buf[NUM_WORDS-1] <= fold_sum[WORD_W-1:0];
            t_buf[NUM_WORDS]   <= WORD_W'(t_top) + WORD_W'(fold_sum[WORD_W]);
            t_top              <= 1'b0;
          end
        end
        S_SUB: y_buf[j_idx] <= diff[WORD_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: doc/monpro_stream.md
# monpro_stream

Parametrised word-serial Montgomery product engine for the ModExp datapath. It computes x·y·R⁻¹ mod n, where R = 2^(WORD_W·NUM_WORDS). Operands stream in one word per accepted beat, gated by a valid/ready handshake rather than fixed timing. It adds two modes: squaring (y = x, y not streamed) and modulus reuse (n kept from the previous operation). The result streams out LS word first, for the exponentiation sequencer.

## Interface
- WORD_W, 128, datapath word width in bits (matches `DATA_WIDTH`).
- NUM_WORDS, 32, words per operand; 32×128 gives 4096-bit operands.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, async active-high reset (fixed)
- start  in  1  single-cycle pulse; sampled only in IDLE
- sq_mode  in  1  sampled with start; 1 = squaring, y load skipped
- keep_n  in  1  sampled with start; 1 = reuse stored modulus (only if n_loaded)
- n_prime  in  WORD_W  −n⁻¹ mod 2^WORD_W; must be stable from start until done
- inp  in  WORD_W  operand word, LS word first
- in_valid  in  1  inp valid this cycle
- in_ready  out  1  engine accepts inp this cycle
- outp  out  WORD_W  result word, LS word first
- out_valid  out  1  outp valid; no backpressure
- done  out  1  pulses with the last result word
- state  out  4  current FSM state encoding (debug)

## Operation
- States: IDLE, LOAD_X, LOAD_Y, LOAD_N, MUL, RED, SUB, OUT.
- IDLE + start → LOAD_X.
- A word is accepted when in_valid & in_ready. in_ready = 1 only in LOAD_* states.
- LOAD_X takes NUM_WORDS words. Next state:
  - LOAD_Y if sq_mode = 0.
  - else LOAD_N if the modulus must be loaded.
  - else MUL.
- LOAD_Y takes NUM_WORDS words → LOAD_N or MUL.
- The modulus must be loaded when keep_n = 0 or n_loaded = 0.
- LOAD_N takes NUM_WORDS words, then sets n_loaded.
- Squaring: the y operand reads the x buffer; no separate copy.
- CIOS loop, outer i = 0..NUM_WORDS−1, accumulator t of NUM_WORDS+2 words, cleared at entry to MUL:
  - MUL (NUM_WORDS+1 cycles): t_j += x_j·y_i + carry; the final cycle folds carry into t_N and t_N+1.
  - RED (NUM_WORDS+1 cycles):
    - First cycle: m = (t_0·n_prime) mod 2^WORD_W.
    - Then t += m·n, shifted down one word, carry into t_N−1 and t_N.
- Width rules:
  - One WORD_W×WORD_W multiplier; the product is 2·WORD_W bits.
  - Per-step sum t_j + a·b + carry fits in 2·WORD_W bits.
  - t_N+1 is 1 bit.
- SUB (NUM_WORDS cycles): d = t − n word-serially with borrow. Select d if t_N = 1 or the final borrow is 0; else select t.
- OUT (NUM_WORDS cycles): out_valid = 1 on consecutive cycles, selected words LS first. done on the last cycle, then → IDLE.
- Requirements on the caller, not checked by the engine:
  - n is odd.
  - x, y < n.
- Result < n.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, done = 0.
  - outp = 0, state = IDLE, n_loaded = 0.
  - Buffers not cleared.
- Latency: from the cycle the last operand word is accepted to the first out_valid is NUM_WORDS·(2·NUM_WORDS+2) + NUM_WORDS + 1 cycles, independent of data and mode.
- in_valid gaps stall loading without losing or duplicating words.
- in_valid is ignored outside LOAD_*.
- start is ignored outside IDLE, including the cycle done is high.
- Reset mid-operation:
  - Immediately → IDLE, outputs return to reset values.
  - n_loaded cleared; the next keep_n = 1 request loads n.
- Back-to-back: start may be asserted the cycle after done.

## Structure
- Shared package `monpro_pkg`:
  - state enum / localparams.
  - word-index counter width = $clog2(NUM_WORDS+2).
  - latency constant for benches.
- One sub-module `mac_word`: combinational a·b + c + d → {hi, lo}, 2·WORD_W bits. Shared by MUL and RED.
- x, y, n, t buffers are register arrays; synthesis may map them to RAM.

## Test plan
All scenarios use WORD_W = 8, NUM_WORDS = 2, n = 0x00F1, n_prime = 0xEF, latency 15 cycles.
- Identity: x = 0x00E1 (R mod n), y = 0x0005 → outp 0x05 then 0x00, out_valid 2 cycles, done on 2nd, first out_valid exactly 15 cycles after last n word.
- Squaring: sq_mode = 1, x = 0x00E1, only x and n streamed (4 beats) → 0xE1, 0x00.
- keep_n: repeat the identity test with keep_n = 1 → LOAD_N skipped, in_ready falls after y; result unchanged. Then assert reset and start with keep_n = 1 → LOAD_N entered.
- Backpressure: in_valid toggled 1-0-0-1 across all loads → same result as the gap-free run; in_ready never high outside LOAD_*.
- Reset mid-RED: reset asserted → state = IDLE and out_valid = 0 that cycle. The next operation x = y = 0 → 0x00, 0x00.
- Random: n = 0xFFF1 and random odd n; 500 operations against a bignum model. Coverage must show both SUB selections taken, and start during busy ignored.
